vfu_issue_ctrl: RTL and testbench

VFU_ISSUE_CTRL -- requirements
Module: vfu_issue_ctrl

---
 rtl/vfu_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vfu_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_issue_ctrl.sv
// Issue controller for the vector functional unit: registers operands onto the VFU,
// tracks each issued op through a fixed-latency tag pipe and buffers results for writeback.
module vfu_issue_ctrl #(
  parameter int VECTOR_LANES = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_STAGES   = 2,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [3:0]                           instr_opcode,
  input  logic [2:0]                           instr_funct,
  input  logic [2:0]                           instr_rnd,
  input  logic [ADDR_WIDTH-1:0]                instr_wb_addr,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   opnd_a,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   opnd_b,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   opnd_c,
  output logic                                 vfu_en,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0]   vfu_vec_a,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0]   vfu_vec_b,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0]   vfu_vec_c,
  output logic [3:0]                           vfu_opcode,
  output logic [2:0]                           vfu_funct,
  output logic [2:0]                           vfu_rnd,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   vfu_vec_out,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [ADDR_WIDTH-1:0]                wb_addr,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0]   wb_data,
  output logic                                 busy
);

  localparam int VW = VECTOR_LANES * DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = NUM_STAGES * ADDR_WIDTH;
  localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);
  localparam logic [PW-1:0] LP_PONE  = PW'(1);

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [NUM_STAGES:0]   w_tag_v_chain;
  logic [TW+ADDR_WIDTH-1:0] w_tag_addr_chain;
  logic [CW-1:0]         w_credit_nxt;
  logic [CW-1:0]         w_count_nxt;

  logic [VW-1:0]         r_vec_a;
  logic [VW-1:0]         r_vec_b;
  logic [VW-1:0]         r_vec_c;
  logic [3:0]            r_opcode;
  logic [2:0]            r_funct;
  logic [2:0]            r_rnd;
  logic [NUM_STAGES-1:0] r_tag_v;
  logic [TW-1:0]         r_tag_addr;
  logic [CW-1:0]         r_credit;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [VW-1:0]         r_mem      [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];

  // Credits cover in-flight tags as well as stored results, so a write can never find the FIFO full.
  assign instr_ready = (r_credit < LP_DEPTH);
  assign busy        = (r_credit != '0);
  assign w_accept    = instr_valid & instr_ready;
  assign w_pop       = wb_valid & wb_ready;
  assign w_wr        = r_tag_v[NUM_STAGES-1];
  assign w_head_addr = r_tag_addr[TW-1 -: ADDR_WIDTH];

  assign w_tag_v_chain    = {r_tag_v, w_accept};
  assign w_tag_addr_chain = {r_tag_addr, instr_wb_addr};

  assign vfu_en     = r_tag_v[0];
  assign vfu_vec_a  = r_vec_a;
  assign vfu_vec_b  = r_vec_b;
  assign vfu_vec_c  = r_vec_c;
  assign vfu_opcode = r_opcode;
  assign vfu_funct  = r_funct;
  assign vfu_rnd    = r_rnd;

  assign wb_valid = (r_count != '0);
  assign wb_data  = wb_valid ? r_mem[r_rd_ptr] : '0;
  assign wb_addr  = wb_valid ? r_mem_addr[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_a  <= '0;
      r_vec_b  <= '0;
      r_vec_c  <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
      r_rnd    <= '0;
    end else if (w_accept) begin
      r_vec_a  <= opnd_a;
      r_vec_b  <= opnd_b;
      r_vec_c  <= opnd_c;
      r_opcode <= instr_opcode;
      r_funct  <= instr_funct;
      r_rnd    <= instr_rnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v    <= '0;
      r_tag_addr <= '0;
    end else begin
      r_tag_v    <= w_tag_v_chain[NUM_STAGES-1:0];
      r_tag_addr <= w_tag_addr_chain[TW-1:0];
    end
  end

  always_comb begin
    w_credit_nxt = r_credit;
    if (w_accept && !w_pop) begin
      w_credit_nxt = r_credit + LP_ONE;
    end else if (!w_accept && w_pop) begin
      w_credit_nxt = r_credit - LP_ONE;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + LP_ONE;
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - LP_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_credit <= w_credit_nxt;
      r_count  <= w_count_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + LP_PONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PONE;
      end
    end
  end

  // Storage needs no reset: outputs are masked by wb_valid, which comes from the reset count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr]      <= vfu_vec_out;
      r_mem_addr[r_wr_ptr] <= w_head_addr;
    end
  end

endmodule

// File: tb/tb_vfu_issue_ctrl.sv
// Directed bench for vfu_issue_ctrl: single issue, backpressure, same-edge pop/accept,
// streaming, mid-operation reset and a latency sweep on 1- and 4-stage instances.
module tb_vfu_issue_ctrl;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          instr_valid, s_valid;
  logic          wb_ready, s_wb_ready;
  logic [3:0]    instr_opcode;
  logic [2:0]    instr_funct, instr_rnd;
  logic [AW-1:0] instr_wb_addr;
  logic [VW-1:0] opnd_a, opnd_b, opnd_c;
  logic [VW-1:0] vfu_vec_out;

  logic          instr_ready, vfu_en, wb_valid, busy;
  logic [VW-1:0] vfu_vec_a, vfu_vec_b, vfu_vec_c, wb_data;
  logic [3:0]    vfu_opcode;
  logic [2:0]    vfu_funct, vfu_rnd;
  logic [AW-1:0] wb_addr;

  logic          s1_ready, s1_en, s1_wb_valid, s1_busy;
  logic [VW-1:0] s1_a, s1_b, s1_c, s1_wb_data;
  logic [3:0]    s1_op;
  logic [2:0]    s1_fn, s1_rnd;
  logic [AW-1:0] s1_wb_addr;

  logic          s4_ready, s4_en, s4_wb_valid, s4_busy;
  logic [VW-1:0] s4_a, s4_b, s4_c, s4_wb_data;
  logic [3:0]    s4_op;
  logic [2:0]    s4_fn, s4_rnd;
  logic [AW-1:0] s4_wb_addr;

  int edge_cnt = 0;
  int n_total = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_pop = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // The VFU result is a known function of the edge it is sampled on.
  function automatic logic [VW-1:0] pat(input int e);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) v[l*DW +: DW] = 32'hC000_0000 | (32'(e) << 8) | 32'(l);
    return v;
  endfunction

  assign vfu_vec_out = pat(edge_cnt);

  vfu_issue_ctrl #(.NUM_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_funct(instr_funct), .instr_rnd(instr_rnd),
    .instr_wb_addr(instr_wb_addr), .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_c(opnd_c),
    .vfu_en(vfu_en), .vfu_vec_a(vfu_vec_a), .vfu_vec_b(vfu_vec_b), .vfu_vec_c(vfu_vec_c),
    .vfu_opcode(vfu_opcode), .vfu_funct(vfu_funct), .vfu_rnd(vfu_rnd),
    .vfu_vec_out(vfu_vec_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  vfu_issue_ctrl #(.NUM_STAGES(1)) u_ns1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(s_valid), .instr_ready(s1_ready),
    .instr_opcode(instr_opcode), .instr_funct(instr_funct), .instr_rnd(instr_rnd),
    .instr_wb_addr(instr_wb_addr), .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_c(opnd_c),
    .vfu_en(s1_en), .vfu_vec_a(s1_a), .vfu_vec_b(s1_b), .vfu_vec_c(s1_c),
    .vfu_opcode(s1_op), .vfu_funct(s1_fn), .vfu_rnd(s1_rnd),
    .vfu_vec_out(vfu_vec_out), .wb_valid(s1_wb_valid), .wb_ready(s_wb_ready),
    .wb_addr(s1_wb_addr), .wb_data(s1_wb_data), .busy(s1_busy)
  );

  vfu_issue_ctrl #(.NUM_STAGES(4)) u_ns4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(s_valid), .instr_ready(s4_ready),
    .instr_opcode(instr_opcode), .instr_funct(instr_funct), .instr_rnd(instr_rnd),
    .instr_wb_addr(instr_wb_addr), .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_c(opnd_c),
    .vfu_en(s4_en), .vfu_vec_a(s4_a), .vfu_vec_b(s4_b), .vfu_vec_c(s4_c),
    .vfu_opcode(s4_op), .vfu_funct(s4_fn), .vfu_rnd(s4_rnd),
    .vfu_vec_out(vfu_vec_out), .wb_valid(s4_wb_valid), .wb_ready(s_wb_ready),
    .wb_addr(s4_wb_addr), .wb_data(s4_wb_data), .busy(s4_busy)
  );

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk("drain_busy", VW'(busy), VW'(0));
  endtask

  // Scoreboard for the 2-stage instance: pushes on acceptance, checks order on every pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", VW'(wb_valid), VW'(0));
        end else begin
          chk("wb_addr_order", VW'(wb_addr), VW'(sb[0].addr));
          chk("wb_data_order", wb_data, sb[0].data);
          sb.delete(0);
        end
        n_pop++;
      end
      if (instr_valid && instr_ready) begin
        sb.push_back('{instr_wb_addr, pat(edge_cnt + 2)});
        n_acc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int e0;
    int acc0;
    int pop0;
    logic exp_rdy [6];
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    instr_valid = 1'b0; s_valid = 1'b0; wb_ready = 1'b0; s_wb_ready = 1'b0;
    instr_opcode = 4'hF; instr_funct = 3'h7; instr_rnd = 3'h7; instr_wb_addr = '1;
    opnd_a = '1; opnd_b = '1; opnd_c = '1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", VW'(instr_ready), VW'(1));
    chk("rst_en", VW'(vfu_en), VW'(0));
    chk("rst_vec_a", vfu_vec_a, VW'(0));
    chk("rst_opcode", VW'(vfu_opcode), VW'(0));
    chk("rst_wb_valid", VW'(wb_valid), VW'(0));
    chk("rst_wb_addr", VW'(wb_addr), VW'(0));
    chk("rst_wb_data", wb_data, VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    instr_valid = 1'b1;
    tick();
    chk("rst_hold_en", VW'(vfu_en), VW'(0));
    tick();

    // Single instruction, offered on the first edge after release.
    rst_n = 1'b1;
    instr_valid = 1'b1; instr_wb_addr = 5'd5; instr_opcode = 4'hA; instr_funct = 3'd3;
    instr_rnd = 3'd2; opnd_a = pat(1000); opnd_b = pat(2000); opnd_c = pat(3000);
    wb_ready = 1'b1;
    e0 = edge_cnt;
    tick();
    instr_valid = 1'b0; opnd_a = pat(9); instr_opcode = 4'h1;
    chk("single_en_c1", VW'(vfu_en), VW'(1));
    chk("single_vec_a", vfu_vec_a, pat(1000));
    chk("single_vec_b", vfu_vec_b, pat(2000));
    chk("single_vec_c", vfu_vec_c, pat(3000));
    chk("single_opcode", VW'(vfu_opcode), VW'(4'hA));
    chk("single_funct", VW'(vfu_funct), VW'(3'd3));
    chk("single_rnd", VW'(vfu_rnd), VW'(3'd2));
    chk("single_busy", VW'(busy), VW'(1));
    chk("single_wbv_c1", VW'(wb_valid), VW'(0));
    tick();
    chk("single_en_c2", VW'(vfu_en), VW'(0));
    chk("single_hold_a", vfu_vec_a, pat(1000));
    chk("single_hold_op", VW'(vfu_opcode), VW'(4'hA));
    chk("single_wbv_c2", VW'(wb_valid), VW'(0));
    tick();
    chk("single_wbv_c3", VW'(wb_valid), VW'(1));
    chk("single_wb_addr", VW'(wb_addr), VW'(5'd5));
    chk("single_wb_data", wb_data, pat(e0 + 2));
    tick();
    chk("single_wbv_c4", VW'(wb_valid), VW'(0));
    chk("single_idle", VW'(busy), VW'(0));

    // Backpressure: six offers, four fit.
    wb_ready = 1'b0;
    e0 = edge_cnt;
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr_wb_addr = AW'(i + 1);
      chk("bp_ready", VW'(instr_ready), VW'(exp_rdy[i]));
      tick();
    end
    instr_valid = 1'b0;
    chk("bp_full_valid", VW'(wb_valid), VW'(1));
    chk("bp_head_addr", VW'(wb_addr), VW'(5'd1));
    chk("bp_ready_full", VW'(instr_ready), VW'(0));
    tick();
    chk("bp_stable_addr", VW'(wb_addr), VW'(5'd1));
    chk("bp_stable_data", wb_data, pat(e0 + 2));
    chk("bp_ready_still", VW'(instr_ready), VW'(0));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("bp_ready_after_pop", VW'(instr_ready), VW'(1));
    chk("bp_next_addr", VW'(wb_addr), VW'(5'd2));

    // Same-edge pop and accept at credit 4 (refused) and at credit 3 (both happen).
    instr_valid = 1'b1; instr_wb_addr = 5'd7;
    tick();
    instr_wb_addr = 5'd8; wb_ready = 1'b1;
    chk("sim4_ready", VW'(instr_ready), VW'(0));
    tick();
    chk("sim4_no_accept", VW'(vfu_en), VW'(0));
    chk("sim4_ready_after", VW'(instr_ready), VW'(1));
    instr_wb_addr = 5'd9;
    tick();
    chk("sim3_accept", VW'(vfu_en), VW'(1));
    chk("sim3_ready", VW'(instr_ready), VW'(1));
    wb_ready = 1'b0; instr_wb_addr = 5'd10;
    tick();
    chk("sim3_fill_accept", VW'(vfu_en), VW'(1));
    chk("sim3_count_was_3", VW'(instr_ready), VW'(0));
    instr_valid = 1'b0; wb_ready = 1'b1;
    wait_idle(20);

    // Streaming: one per cycle with a consumer that never stalls.
    acc0 = n_acc; pop0 = n_pop;
    wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr_valid = 1'b1;
      instr_wb_addr = AW'(i + 11);
      chk("stream_ready", VW'(instr_ready), VW'(1));
      tick();
    end
    instr_valid = 1'b0;
    chk("stream_acc", VW'(n_acc - acc0), VW'(20));
    wait_idle(20);
    chk("stream_pop", VW'(n_pop - pop0), VW'(20));

    // Reset with two results buffered and two still in the pipe.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr_wb_addr = AW'(20 + i);
      tick();
    end
    instr_valid = 1'b0;
    chk("mid_pre_valid", VW'(wb_valid), VW'(1));
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_wb_valid", VW'(wb_valid), VW'(0));
    chk("mid_busy", VW'(busy), VW'(0));
    chk("mid_ready", VW'(instr_ready), VW'(1));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_wbv", VW'(wb_valid), VW'(0));
      chk("post_rst_busy", VW'(busy), VW'(0));
    end

    // Latency sweep on the 1- and 4-stage instances.
    s_wb_ready = 1'b0; s_valid = 1'b1; instr_wb_addr = 5'd17;
    e0 = edge_cnt;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("ns1_valid", VW'(s1_wb_valid), VW'(k >= 1));
      chk("ns4_valid", VW'(s4_wb_valid), VW'(k >= 4));
      tick();
    end
    chk("ns1_data", s1_wb_data, pat(e0 + 1));
    chk("ns4_data", s4_wb_data, pat(e0 + 4));
    chk("ns1_addr", VW'(s1_wb_addr), VW'(5'd17));
    chk("ns4_addr", VW'(s4_wb_addr), VW'(5'd17));
    s_wb_ready = 1'b1;
    tick();
    s_wb_ready = 1'b0;
    chk("ns1_popped", VW'(s1_wb_valid), VW'(0));
    chk("ns4_popped", VW'(s4_wb_valid), VW'(0));
    chk("ns1_idle", VW'(s1_busy), VW'(0));
    chk("ns4_idle", VW'(s4_busy), VW'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
